// File: rtl/car_alarm_siren_ctrl_if.sv
// Signal bundle between the alarm sequencer and its driver/monitor side:
// arm/disarm/alarm requests in, state and siren/horn/LED drive out.
interface car_alarm_siren_ctrl_if;
    logic       alarm_in;
    logic       arm;
    logic       disarm;
    logic [2:0] state;
    logic       armed_led;
    logic       siren;
    logic       horn;
    logic [3:0] trigger_count;

    modport master (
        output alarm_in, arm, disarm,
        input  state, armed_led, siren, horn, trigger_count
    );

    modport slave (
        input  alarm_in, arm, disarm,
        output state, armed_led, siren, horn, trigger_count
    );
endinterface

// File: rtl/car_alarm_siren_ctrl.sv
// Car alarm response sequencer: exit delay, entry delay, timed siren with
// pulsed horn and a saturating count of siren entries since the last arm.
module car_alarm_siren_ctrl #(
    parameter int unsigned EXIT_DELAY  = 16,
    parameter int unsigned ENTRY_DELAY = 8,
    parameter int unsigned SIREN_TIME  = 32,
    parameter int unsigned HORN_HALF   = 2,
    parameter int unsigned CNT_W       = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    car_alarm_siren_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        ARMING   = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        SIREN    = 3'd4
    } stateT;

    // Counters hold "cycles remaining - 1", so a parameter of 2^CNT_W still fits.
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);
    localparam logic [CNT_W-1:0] HORN_LAST  = CNT_W'(HORN_HALF - 1);

    stateT            stateQ;
    logic [CNT_W-1:0] delayCnt;
    logic [CNT_W-1:0] hornCnt;
    logic             hornQ;
    logic [3:0]       trigCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ   <= DISARMED;
            delayCnt <= '0;
            hornCnt  <= '0;
            hornQ    <= 1'b0;
            trigCnt  <= '0;
        end else if (bus.disarm) begin
            stateQ   <= DISARMED;
            delayCnt <= '0;
            hornCnt  <= '0;
            hornQ    <= 1'b0;
        end else begin
            case (stateQ)
                DISARMED: begin
                    if (bus.arm) begin
                        stateQ   <= ARMING;
                        delayCnt <= EXIT_LOAD;
                        trigCnt  <= '0;
                    end
                end
                ARMING: begin
                    if (delayCnt == '0) stateQ <= ARMED;
                    else                delayCnt <= delayCnt - 1'b1;
                end
                ARMED: begin
                    if (bus.alarm_in) begin
                        stateQ   <= ENTRY;
                        delayCnt <= ENTRY_LOAD;
                    end
                end
                ENTRY: begin
                    if (delayCnt == '0) begin
                        stateQ   <= SIREN;
                        delayCnt <= SIREN_LOAD;
                        hornCnt  <= '0;
                        hornQ    <= 1'b1;
                        if (trigCnt != 4'hF) trigCnt <= trigCnt + 4'd1;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                SIREN: begin
                    if (delayCnt == '0) begin
                        stateQ  <= ARMED;
                        hornCnt <= '0;
                        hornQ   <= 1'b0;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                        if (hornCnt == HORN_LAST) begin
                            hornCnt <= '0;
                            hornQ   <= ~hornQ;
                        end else begin
                            hornCnt <= hornCnt + 1'b1;
                        end
                    end
                end
                default: begin
                    stateQ   <= DISARMED;
                    delayCnt <= '0;
                    hornCnt  <= '0;
                    hornQ    <= 1'b0;
                end
            endcase
        end
    end

    // Pure decodes of the state register; no input reaches an output combinationally.
    assign bus.state         = stateQ;
    assign bus.armed_led     = (stateQ == ARMED) || (stateQ == ENTRY) || (stateQ == SIREN);
    assign bus.siren         = (stateQ == SIREN);
    assign bus.horn          = hornQ;
    assign bus.trigger_count = trigCnt;

endmodule

// File: tb/tb_car_alarm_siren_ctrl.sv
// Self-checking bench for car_alarm_siren_ctrl: default instance for the
// main sequences, a short-timing instance for trigger-count saturation.
module tb_car_alarm_siren_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       led;
        logic       sir;
        logic       hrn;
        logic [3:0] trg;
    } expT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    expT  expQ[$];

    always #5 clk = ~clk;

    car_alarm_siren_ctrl_if ifA ();
    car_alarm_siren_ctrl_if ifB ();

    car_alarm_siren_ctrl dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    car_alarm_siren_ctrl #(
        .EXIT_DELAY  (1),
        .ENTRY_DELAY (1),
        .SIREN_TIME  (1),
        .HORN_HALF   (1),
        .CNT_W       (8)
    ) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    function automatic expT mk(input logic [2:0] st, input logic h, input logic [3:0] t);
        expT x;
        x.st  = st;
        x.led = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
        x.sir = (st == 3'd4);
        x.hrn = h;
        x.trg = t;
        return x;
    endfunction

    task automatic test_reset();
        expT x, gotA, gotB;
        rst_n = 1'b0;
        ifA.alarm_in = 1'b1; ifA.arm = 1'b0; ifA.disarm = 1'b0;
        ifB.alarm_in = 1'b0; ifB.arm = 1'b0; ifB.disarm = 1'b0;
        for (int e = 0; e < 22; e++) begin
            if (e == 2) rst_n = 1'b1;
            expQ.push_back(mk(3'd0, 1'b0, 4'd0));
            @(posedge clk); #1;
            x = expQ.pop_front();
            gotA = {ifA.state, ifA.armed_led, ifA.siren, ifA.horn, ifA.trigger_count};
            gotB = {ifB.state, ifB.armed_led, ifB.siren, ifB.horn, ifB.trigger_count};
            checks += 2;
            if (gotA !== x) begin
                failures++;
                $display("FAIL reset_idle e=%0d got=%h exp=%h", e, gotA, x);
            end
            if (gotB !== x) begin
                failures++;
                $display("FAIL reset_idle_b e=%0d got=%h exp=%h", e, gotB, x);
            end
        end
        ifA.alarm_in = 1'b0;
    endtask

    task automatic test_full_cycle();
        expT x, got;
        for (int e = 0; e <= 64; e++) begin
            ifA.arm = (e == 0);
            ifA.alarm_in = (e == 20);
            ifA.disarm = 1'b0;
            if (e <= 15)      x = mk(3'd1, 1'b0, 4'd0);
            else if (e <= 19) x = mk(3'd2, 1'b0, 4'd0);
            else if (e <= 27) x = mk(3'd3, 1'b0, 4'd0);
            else if (e <= 59) x = mk(3'd4, (((e - 28) / 2) % 2) == 0, 4'd1);
            else              x = mk(3'd2, 1'b0, 4'd1);
            expQ.push_back(x);
            @(posedge clk); #1;
            x = expQ.pop_front();
            got = {ifA.state, ifA.armed_led, ifA.siren, ifA.horn, ifA.trigger_count};
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL full_cycle e=%0d got=%h exp=%h", e, got, x);
            end
        end
        ifA.arm = 1'b0; ifA.alarm_in = 1'b0;
    endtask

    task automatic test_alarm_during_arming();
        expT x, got;
        for (int e = -1; e <= 25; e++) begin
            ifA.disarm = (e == -1) || (e == 21);
            ifA.arm = (e == 0);
            ifA.alarm_in = (e >= 0);
            if (e == -1)      x = mk(3'd0, 1'b0, 4'd1);
            else if (e <= 15) x = mk(3'd1, 1'b0, 4'd0);
            else if (e == 16) x = mk(3'd2, 1'b0, 4'd0);
            else if (e <= 20) x = mk(3'd3, 1'b0, 4'd0);
            else              x = mk(3'd0, 1'b0, 4'd0);
            expQ.push_back(x);
            @(posedge clk); #1;
            x = expQ.pop_front();
            got = {ifA.state, ifA.armed_led, ifA.siren, ifA.horn, ifA.trigger_count};
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL arming_entry_disarm e=%0d got=%h exp=%h", e, got, x);
            end
        end
        ifA.arm = 1'b0; ifA.alarm_in = 1'b0; ifA.disarm = 1'b0;
    endtask

    task automatic test_siren_disarm();
        expT x, got;
        for (int e = 0; e <= 33; e++) begin
            ifA.arm = (e == 0);
            ifA.alarm_in = (e >= 16);
            ifA.disarm = (e == 31);
            if (e <= 15)      x = mk(3'd1, 1'b0, 4'd0);
            else if (e == 16) x = mk(3'd2, 1'b0, 4'd0);
            else if (e <= 24) x = mk(3'd3, 1'b0, 4'd0);
            else if (e <= 30) x = mk(3'd4, (((e - 25) / 2) % 2) == 0, 4'd1);
            else              x = mk(3'd0, 1'b0, 4'd1);
            expQ.push_back(x);
            @(posedge clk); #1;
            x = expQ.pop_front();
            got = {ifA.state, ifA.armed_led, ifA.siren, ifA.horn, ifA.trigger_count};
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL siren_disarm e=%0d got=%h exp=%h", e, got, x);
            end
        end
        ifA.arm = 1'b0; ifA.alarm_in = 1'b0; ifA.disarm = 1'b0;
    endtask

    task automatic test_priority();
        expT x, got;
        for (int e = 0; e < 3; e++) begin
            ifA.arm = 1'b1; ifA.disarm = 1'b1; ifA.alarm_in = 1'b1;
            expQ.push_back(mk(3'd0, 1'b0, 4'd1));
            @(posedge clk); #1;
            x = expQ.pop_front();
            got = {ifA.state, ifA.armed_led, ifA.siren, ifA.horn, ifA.trigger_count};
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL arm_disarm_priority e=%0d got=%h exp=%h", e, got, x);
            end
        end
        ifA.arm = 1'b0; ifA.alarm_in = 1'b0; ifA.disarm = 1'b0;
    endtask

    task automatic test_saturation();
        expT x, got;
        int k;
        for (int e = 0; e <= 52; e++) begin
            ifB.arm = (e == 0);
            ifB.alarm_in = 1'b1;
            k = (e / 3 > 15) ? 15 : e / 3;
            if (e == 0)          x = mk(3'd1, 1'b0, 4'd0);
            else if (e % 3 == 0) x = mk(3'd4, 1'b1, 4'(k));
            else if (e % 3 == 1) x = mk(3'd2, 1'b0, 4'(k));
            else                 x = mk(3'd3, 1'b0, 4'(k));
            expQ.push_back(x);
            @(posedge clk); #1;
            x = expQ.pop_front();
            got = {ifB.state, ifB.armed_led, ifB.siren, ifB.horn, ifB.trigger_count};
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL saturation e=%0d got=%h exp=%h", e, got, x);
            end
        end
        ifB.arm = 1'b0; ifB.alarm_in = 1'b0;
    endtask

    task automatic test_reset_mid_siren();
        expT x, got;
        for (int e = 0; e <= 30; e++) begin
            ifA.arm = (e == 0);
            ifA.alarm_in = (e >= 16);
            ifA.disarm = 1'b0;
            rst_n = (e != 27);
            if (e <= 15)      x = mk(3'd1, 1'b0, 4'd0);
            else if (e == 16) x = mk(3'd2, 1'b0, 4'd0);
            else if (e <= 24) x = mk(3'd3, 1'b0, 4'd0);
            else if (e <= 26) x = mk(3'd4, (((e - 25) / 2) % 2) == 0, 4'd1);
            else              x = mk(3'd0, 1'b0, 4'd0);
            expQ.push_back(x);
            @(posedge clk); #1;
            x = expQ.pop_front();
            got = {ifA.state, ifA.armed_led, ifA.siren, ifA.horn, ifA.trigger_count};
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL reset_mid_siren e=%0d got=%h exp=%h", e, got, x);
            end
        end
        rst_n = 1'b1;
        ifA.arm = 1'b0; ifA.alarm_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_alarm_during_arming();
        test_siren_disarm();
        test_priority();
        test_saturation();
        test_reset_mid_siren();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/car_alarm_siren_ctrl.md
# car_alarm_siren_ctrl

Downstream consumer of the car-alarm detection logic: takes the single-bit alarm signal (from the structural or behavioural alarm description) plus driver arm/disarm requests and sequences the vehicle's response. Implements a Moore state machine with exit delay, entry delay, timed siren with pulsed horn, and a saturating trigger counter. Sits between the alarm-condition logic and the siren/horn/LED drivers; all outputs are registered.

## Interface
- EXIT_DELAY, 16: cycles spent in ARMING before ARMED (legal 1..2^CNT_W)
- ENTRY_DELAY, 8: cycles spent in ENTRY before SIREN (legal 1..2^CNT_W)
- SIREN_TIME, 32: cycles spent in SIREN (legal 1..2^CNT_W)
- HORN_HALF, 2: horn high/low half-period in cycles (legal 1..2^CNT_W)
- CNT_W, 8: width of delay and horn counters
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- alarm_in  input  1  alarm condition from upstream detection logic, same clock domain
- arm  input  1  arm request, level-sampled each edge
- disarm  input  1  disarm request, level-sampled each edge
- state  output  3  current state encoding
- armed_led  output  1  high in ARMED, ENTRY, SIREN
- siren  output  1  high only in SIREN
- horn  output  1  pulsed in SIREN, else 0
- trigger_count  output  4  number of SIREN entries since last arm, saturates at 15

## Operation
- States / encodings: DISARMED=0, ARMING=1, ARMED=2, ENTRY=3, SIREN=4; codes 5-7 unreachable, recover to DISARMED next edge.
- Input priority at every edge: rst_n low > disarm > arm > alarm_in.
- DISARMED: arm=1 -> ARMING, delay counter loaded EXIT_DELAY-1, trigger_count cleared to 0. alarm_in ignored.
- ARMING: counter decrements; alarm_in ignored; counter==0 -> ARMED.
- ARMED: alarm_in=1 -> ENTRY, counter loaded ENTRY_DELAY-1.
- ENTRY: counter decrements; alarm_in dropping does not cancel; counter==0 -> SIREN, counter loaded SIREN_TIME-1, trigger_count += 1 (saturating at 15), horn phase counter cleared, horn set 1.
- SIREN: counter decrements; horn toggles every HORN_HALF cycles, first phase high; counter==0 -> ARMED (alarm_in still high then re-enters ENTRY on the following edge).
- disarm=1 in any non-DISARMED state -> DISARMED next edge; trigger_count holds its value.
- arm=1 outside DISARMED ignored. arm and disarm both high: disarm wins.
- Outputs are decoded from registered state/horn flop; no combinational path from inputs to outputs.

## Timing
- Reset (rst_n low at an edge): state=DISARMED, armed_led=0, siren=0, horn=0, trigger_count=0, counters=0. Reset mid-SIREN silences outputs after that edge.
- arm sampled high at edge k: state=ARMING after edge k; ARMED after edge k+EXIT_DELAY.
- alarm_in high at edge m in ARMED: ENTRY after m; SIREN after m+ENTRY_DELAY; ARMED again after m+ENTRY_DELAY+SIREN_TIME.
- Each timed state occupies exactly its parameter's number of cycles; parameter value 1 gives a single-cycle visit.
- Horn in SIREN: cycles 0..HORN_HALF-1 high, next HORN_HALF low, repeating; SIREN_TIME not multiple of 2*HORN_HALF truncates last phase; horn=0 on SIREN exit edge.
- Output latency from any input: one edge.

## Test plan
- Reset/idle: rst_n low 2 cycles, then alarm_in=1 with no arm for 20 cycles -> state=0, all outputs 0 throughout.
- Full alarm cycle (defaults): arm pulse at edge 0; alarm_in=1 at edge 20 -> ARMING edges 0..15, ARMED at 16, ENTRY after 20, SIREN after 28 with trigger_count=1, horn pattern 1,1,0,0 repeating for 32 cycles, ARMED after 60.
- Alarm during ARMING: alarm_in=1 throughout exit delay -> no ENTRY until ARMED reached, then ENTRY on next edge.
- Disarm in ENTRY and SIREN: disarm at ENTRY cycle 3 -> DISARMED, siren never asserts; disarm at SIREN cycle 5 -> siren, horn, armed_led 0 next edge, trigger_count retained.
- Saturation/retrigger: alarm_in held high 17 siren cycles with ENTRY_DELAY=1, SIREN_TIME=1 -> trigger_count stops at 15.
- Priority/reset mid-op: arm and disarm both high in DISARMED -> stays DISARMED; rst_n low during SIREN -> all outputs 0 after that edge.
